// File: rtl/sim_run_ctrl_if.sv
// Core-facing signals of the run controller: halt/commit from the core,
// reset/run status and counters back out.
interface sim_run_ctrl_if #(
  parameter int unsigned CNT_WIDTH = 32
);
  logic                 halt_in;
  logic                 commit_in;
  logic                 core_rst_out;
  logic                 running_out;
  logic                 done_out;
  logic [1:0]           status_out;
  logic [CNT_WIDTH-1:0] cycle_cnt_out;
  logic [CNT_WIDTH-1:0] commit_cnt_out;

  modport slave (
    input  halt_in, commit_in,
    output core_rst_out, running_out, done_out, status_out,
           cycle_cnt_out, commit_cnt_out
  );

  modport master (
    output halt_in, commit_in,
    input  core_rst_out, running_out, done_out, status_out,
           cycle_cnt_out, commit_cnt_out
  );
endinterface

// File: rtl/sim_run_ctrl.sv
// Run controller: stretches reset into a fixed-length core reset, then counts
// run cycles and retired instructions until halt, timeout or commit stall.
module sim_run_ctrl #(
  parameter int unsigned RST_CYCLES     = 25,
  parameter int unsigned TIMEOUT_CYCLES = 100,
  parameter int unsigned STALL_LIMIT    = 0,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic           clk_in,
  input  logic           rst_in,
  sim_run_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {HOLD, RUN, DONE} state_e;

  localparam int unsigned HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HW-1:0]        HOLD_LAST  = HW'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [CNT_WIDTH-1:0] TO_LAST    = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STALL_LAST = CNT_WIDTH'(STALL_LIMIT - 1);

  localparam logic [1:0] ST_NONE    = 2'b00;
  localparam logic [1:0] ST_HALT    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_STALL   = 2'b11;

  state_e               state_q, state_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic                 core_rst_q, core_rst_d;
  logic                 running_q, running_d;
  logic                 done_q, done_d;
  logic [1:0]           status_q, status_d;
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
  logic [CNT_WIDTH-1:0] com_q, com_d;
  logic [CNT_WIDTH-1:0] idle_q, idle_d;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    core_rst_d = core_rst_q;
    running_d  = running_q;
    done_d     = done_q;
    status_d   = status_q;
    cyc_d      = cyc_q;
    com_d      = com_q;
    idle_d     = idle_q;

    unique case (state_q)
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d    = RUN;
          core_rst_d = 1'b0;
          running_d  = 1'b1;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      RUN: begin
        cyc_d = (cyc_q == CNT_MAX) ? cyc_q : cyc_q + CNT_WIDTH'(1);
        if (bus.commit_in) begin
          com_d  = (com_q == CNT_MAX) ? com_q : com_q + CNT_WIDTH'(1);
          idle_d = '0;
        end else begin
          idle_d = (idle_q == CNT_MAX) ? idle_q : idle_q + CNT_WIDTH'(1);
        end
        // Termination tests use pre-update counts so the last edge still counts.
        if (bus.halt_in) begin
          status_d = ST_HALT;
        end else if (TIMEOUT_CYCLES != 0 && cyc_q == TO_LAST) begin
          status_d = ST_TIMEOUT;
        end else if (STALL_LIMIT != 0 && !bus.commit_in && idle_q == STALL_LAST) begin
          status_d = ST_STALL;
        end
        if (status_d != ST_NONE) begin
          state_d   = DONE;
          done_d    = 1'b1;
          running_d = 1'b0;
        end
      end
      DONE: ;
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= HOLD;
      hold_q     <= '0;
      core_rst_q <= 1'b1;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      status_q   <= ST_NONE;
      cyc_q      <= '0;
      com_q      <= '0;
      idle_q     <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      core_rst_q <= core_rst_d;
      running_q  <= running_d;
      done_q     <= done_d;
      status_q   <= status_d;
      cyc_q      <= cyc_d;
      com_q      <= com_d;
      idle_q     <= idle_d;
    end
  end

  assign bus.core_rst_out   = core_rst_q;
  assign bus.running_out    = running_q;
  assign bus.done_out       = done_q;
  assign bus.status_out     = status_q;
  assign bus.cycle_cnt_out  = cyc_q;
  assign bus.commit_cnt_out = com_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Two controllers with different parameters share one stimulus stream; each
// edge's expected outputs are queued and compared by a separate monitor.
module tb_sim_run_ctrl;

  localparam int unsigned A_RST = 25, A_TO = 100, A_ST = 0, A_W = 32;
  localparam int unsigned B_RST = 3,  B_TO = 0,   B_ST = 8, B_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sim_run_ctrl_if #(.CNT_WIDTH(A_W)) ifa ();
  sim_run_ctrl_if #(.CNT_WIDTH(B_W)) ifb ();

  sim_run_ctrl #(.RST_CYCLES(A_RST), .TIMEOUT_CYCLES(A_TO), .STALL_LIMIT(A_ST), .CNT_WIDTH(A_W))
    dut_a (.clk_in(clk), .rst_in(rst), .bus(ifa.slave));
  sim_run_ctrl #(.RST_CYCLES(B_RST), .TIMEOUT_CYCLES(B_TO), .STALL_LIMIT(B_ST), .CNT_WIDTH(B_W))
    dut_b (.clk_in(clk), .rst_in(rst), .bus(ifb.slave));

  // Behavioural view: edges since reset release, a finished flag, and
  // unbounded counts that are clipped only when forming expected outputs.
  typedef struct {
    int     since;
    bit     fin;
    int     stat;
    longint cyc;
    longint com;
    longint idle;
  } mdl_t;

  typedef logic [68:0] obs_t;

  mdl_t ma, mb;
  obs_t qa[$], qb[$];
  int unsigned n_chk = 0, n_pass = 0;

  function automatic mdl_t mstep(mdl_t m, bit r, bit h, bit c, int rstc, int to, int stl);
    mdl_t n = m;
    if (r) begin
      n.since = 0; n.fin = 0; n.stat = 0; n.cyc = 0; n.com = 0; n.idle = 0;
    end else if (n.since < rstc) begin
      n.since++;
    end else if (!n.fin) begin
      n.cyc++;
      if (c) begin n.com++; n.idle = 0; end
      else n.idle++;
      if (h) n.stat = 1;
      else if (to != 0 && n.cyc == to) n.stat = 2;
      else if (stl != 0 && !c && n.idle == stl) n.stat = 3;
      n.fin = (n.stat != 0);
    end
    return n;
  endfunction

  function automatic obs_t mexp(mdl_t m, int rstc, int w);
    longint mx = (longint'(1) << w) - 1;
    longint cy = (m.cyc > mx) ? mx : m.cyc;
    longint cm = (m.com > mx) ? mx : m.com;
    bit core = (m.since < rstc);
    bit run  = !core && !m.fin;
    return {core, run, m.fin, 2'(m.stat), 32'(cy), 32'(cm)};
  endfunction

  function automatic obs_t pack_a();
    return {ifa.core_rst_out, ifa.running_out, ifa.done_out, ifa.status_out,
            ifa.cycle_cnt_out, ifa.commit_cnt_out};
  endfunction

  function automatic obs_t pack_b();
    return {ifb.core_rst_out, ifb.running_out, ifb.done_out, ifb.status_out,
            32'(ifb.cycle_cnt_out), 32'(ifb.commit_cnt_out)};
  endfunction

  task automatic check(string name, obs_t act, obs_t exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(posedge clk) begin
    #1;
    if (qa.size() != 0) check("a_edge", pack_a(), qa.pop_front());
    if (qb.size() != 0) check("b_edge", pack_b(), qb.pop_front());
  end

  task automatic step(bit r, bit h, bit c);
    @(negedge clk);
    rst = r;
    ifa.halt_in = h; ifa.commit_in = c;
    ifb.halt_in = h; ifb.commit_in = c;
    ma = mstep(ma, r, h, c, A_RST, A_TO, A_ST);
    mb = mstep(mb, r, h, c, B_RST, B_TO, B_ST);
    qa.push_back(mexp(ma, A_RST, A_W));
    qb.push_back(mexp(mb, B_RST, B_W));
    @(posedge clk);
    #2;
  endtask

  task automatic reset_hold(bit c);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (A_RST) step(1'b0, 1'b0, c);
  endtask

  initial begin
    ifa.halt_in = 0; ifa.commit_in = 0;
    ifb.halt_in = 0; ifb.commit_in = 0;

    // Reset release and hold length
    repeat (3) step(1'b1, 1'b0, 1'b0);
    check("rst_core", 69'(ifa.core_rst_out), 69'(1));
    check("rst_cnt", 69'(ifa.cycle_cnt_out), 69'(0));
    for (int i = 0; i < int'(A_RST); i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (i == int'(A_RST) - 2) check("hold_last_high", 69'(ifa.core_rst_out), 69'(1));
      if (i == int'(A_RST) - 1) check("hold_release", 69'({ifa.core_rst_out, ifa.running_out}), 69'(2'b01));
    end

    // Timeout on A, stall on B
    repeat (100) step(1'b0, 1'b0, 1'b0);
    check("to_status", 69'({ifa.done_out, ifa.status_out}), 69'(3'b110));
    check("to_cycles", 69'(ifa.cycle_cnt_out), 69'(100));
    check("b_stall_status", 69'(ifb.status_out), 69'(3));
    repeat (20) step(1'b0, 1'b0, 1'b0);
    check("to_frozen", 69'(ifa.cycle_cnt_out), 69'(100));

    // Halt with commit; B saturates at 15
    reset_hold(1'b1);
    repeat (40) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("halt_status", 69'(ifa.status_out), 69'(1));
    check("halt_commits", 69'(ifa.commit_cnt_out), 69'(41));
    check("halt_cycles", 69'(ifa.cycle_cnt_out), 69'(41));
    check("b_sat", 69'({ifb.cycle_cnt_out, ifb.commit_cnt_out}), 69'(8'hff));

    // Halt beats timeout on the same edge
    reset_hold(1'b0);
    repeat (99) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("prio_status", 69'(ifa.status_out), 69'(1));
    check("prio_cycles", 69'(ifa.cycle_cnt_out), 69'(100));

    // B stall: last commit on run cycle 5, ends after run cycle 13
    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (B_RST + 5) step(1'b0, 1'b0, 1'b1);
    repeat (7) step(1'b0, 1'b0, 1'b0);
    check("b_not_yet", 69'(ifb.done_out), 69'(0));
    step(1'b0, 1'b0, 1'b0);
    check("b_stall", 69'({ifb.status_out, ifb.cycle_cnt_out}), 69'({2'b11, 4'd13}));

    // Reset mid-run, halt pulses ignored during hold
    repeat (3) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < int'(A_RST); i++) step(1'b0, (i % 4) == 1, 1'b0);
    repeat (29) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    check("mid_rst", 69'({ifa.core_rst_out, ifa.running_out, ifa.done_out,
                          ifa.status_out, ifa.cycle_cnt_out, ifa.commit_cnt_out}),
          {1'b1, 68'(0)});
    for (int i = 0; i < int'(A_RST); i++) step(1'b0, (i % 3) == 0, 1'b0);
    check("hold_halt_ignored", 69'({ifa.running_out, ifa.done_out}), 69'(2'b10));

    // Randomised episodes
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 299) == 0, $urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1);

    step(1'b0, 1'b0, 1'b0);
    if (qa.size() != 0 || qb.size() != 0) begin
      n_chk++;
      $display("FAIL drain: got %0d/%0d pending expected 0", qa.size(), qb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sim_run_ctrl.md
Name: sim_run_ctrl

Overview:
- Parametrised run controller between the bench/board reset and the CPU core; replaces hard-coded reset length and fixed run time.
- Stretches external reset into a core reset of fixed length, then counts run cycles and retired instructions.
- Ends the run on program halt, cycle timeout or commit stall, with a sticky done flag and status code.
- Synthesisable; sits inside the top level, so both simulation and FPGA builds use it.

Parameters:
- RST_CYCLES, 25: cycles core_rst_out stays high after rst_in drops (≥1).
- TIMEOUT_CYCLES, 100: RUN cycles before forced termination; 0 disables.
- STALL_LIMIT, 0: consecutive RUN cycles without commit_in before termination; 0 disables.
- CNT_WIDTH, 32: width of both counters.

Ports:
- clk_in  input  1  system clock; single clock domain.
- rst_in  input  1  reset, synchronous, active-high.
- halt_in  input  1  program-end pulse from core/IO.
- commit_in  input  1  one-cycle pulse per retired instruction.
- core_rst_out  output  1  registered reset to the core.
- running_out  output  1  high while in RUN.
- done_out  output  1  sticky run-finished flag.
- status_out  output  2  00 none, 01 halt, 10 timeout, 11 stall.
- cycle_cnt_out  output  CNT_WIDTH  RUN cycles elapsed.
- commit_cnt_out  output  CNT_WIDTH  instructions retired in RUN.

Behaviour:
- States: HOLD, RUN, DONE. All outputs are registered.
- Reset: any edge with rst_in=1 gives state HOLD, hold counter 0, core_rst_out=1, running_out=0, done_out=0, status_out=00, both counters 0, idle counter 0.
- Reset applies from any state, including mid-RUN and DONE; nothing from the old run survives.
- HOLD:
  - Hold counter increments on each edge with rst_in=0.
  - On the edge where the hold counter equals RST_CYCLES-1, go to RUN: core_rst_out=0, running_out=1.
  - Result: core_rst_out is high for exactly RST_CYCLES cycles after the first rst_in=0 edge.
  - halt_in and commit_in are ignored in HOLD.
- RUN, per edge:
  - cycle_cnt += 1.
  - commit_cnt += commit_in.
  - Idle counter clears on commit_in, otherwise increments.
  - Both main counters saturate at all-ones and never wrap.
- Termination, evaluated on the same edge, priority halt > timeout > stall:
  - halt_in=1: DONE, status 01.
  - TIMEOUT_CYCLES≠0 and cycle_cnt_out==TIMEOUT_CYCLES-1: DONE, status 10.
  - STALL_LIMIT≠0, commit_in=0 and idle counter==STALL_LIMIT-1: DONE, status 11.
  - The terminating edge still updates both counters, including a commit arriving with halt_in.
  - On that edge: done_out=1, running_out=0.
- DONE:
  - All counters frozen; core_rst_out stays 0.
  - halt_in and commit_in are ignored.
  - Only rst_in leaves DONE.
- Timeout count: a timeout run ends with cycle_cnt_out==TIMEOUT_CYCLES.

Test Plan:
- Reset and hold: RST_CYCLES=25, rst_in high 3 cycles, then low → core_rst_out high exactly 25 cycles after the release edge, then 0; running_out=1 on the same edge; counters 0.
- Timeout: TIMEOUT_CYCLES=100, no halt or commit, STALL_LIMIT=0 → done_out=1 and status 10 after 100 RUN cycles; cycle_cnt_out=100 and frozen 20 cycles later.
- Halt with commit: commit_in on RUN cycles 1..40, then halt_in with commit_in on RUN cycle 41 → status 01, commit_cnt_out=41, cycle_cnt_out=41.
- Priority and stall:
  - halt_in on RUN cycle 100 with TIMEOUT_CYCLES=100 → status 01, not 10.
  - STALL_LIMIT=8, TIMEOUT_CYCLES=0, last commit on RUN cycle 5 → status 11 after RUN cycle 13.
- Reset mid-run: rst_in pulse at RUN cycle 30 → all outputs return to reset values next edge; a fresh 25-cycle hold follows; halt_in pulses during the hold are ignored.
- Saturation: CNT_WIDTH=4, TIMEOUT_CYCLES=0, commit_in held high 20 cycles → both counters hold at 15.
